// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: full-canvas clears and clipped square brush stamps,
// emitted one pixel per cycle on a registered write port.
module fb_write_scheduler #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 20,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_color,
    input  logic                  stamp_valid,
    output logic                  stamp_ready,
    input  logic [9:0]            stamp_x,
    input  logic [9:0]            stamp_y,
    input  logic [2:0]            stamp_size,
    input  logic [DATA_WIDTH-1:0] stamp_color,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] STAMP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);

    logic [1:0]            state;
    logic                  clear_pending;
    logic [9:0]            sx, sy;
    logic [2:0]            ssize, ox, oy;

    logic [9:0]            bx, by;
    logic [2:0]            nox, noy;
    logic [10:0]           px, py;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  p_in;
    logic                  stamp_last;

    assign stamp_ready = !rst && (state == IDLE) && !clear_req && !clear_pending;

    // Position about to be emitted: the stamp origin on acceptance, else the next offset.
    always_comb begin
        bx  = stamp_x;
        by  = stamp_y;
        nox = '0;
        noy = '0;
        if (state == STAMP) begin
            bx = sx;
            by = sy;
            if (ox == ssize) begin
                noy = oy + 3'd1;
            end else begin
                nox = ox + 3'd1;
                noy = oy;
            end
        end
        px         = {1'b0, bx} + {8'd0, nox};
        py         = {1'b0, by} + {8'd0, noy};
        paddr      = ADDR_WIDTH'(py) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(px);
        p_in       = ({21'd0, px} < 32'(H_RES)) && ({21'd0, py} < 32'(V_RES));
        stamp_last = (ox == ssize) && (oy == ssize);
        addr_inc   = mem_addr + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            sx            <= '0;
            sy            <= '0;
            ssize         <= '0;
            ox            <= '0;
            oy            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_din    <= clear_color;
                        clear_done <= (LAST_ADDR == '0);
                    end else if (stamp_valid) begin
                        state    <= STAMP;
                        sx       <= stamp_x;
                        sy       <= stamp_y;
                        ssize    <= stamp_size;
                        ox       <= '0;
                        oy       <= '0;
                        busy     <= 1'b1;
                        mem_we   <= p_in;
                        mem_addr <= paddr;
                        mem_din  <= stamp_color;
                    end
                end
                CLEAR: begin
                    if (mem_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        mem_we     <= 1'b0;
                        clear_done <= 1'b0;
                    end else begin
                        mem_addr   <= addr_inc;
                        clear_done <= (addr_inc == LAST_ADDR);
                    end
                end
                STAMP: begin
                    if (stamp_last) begin
                        // A clear requested during the stamp follows back-to-back.
                        if (clear_req || clear_pending) begin
                            state         <= CLEAR;
                            clear_pending <= 1'b0;
                            busy          <= 1'b1;
                            mem_we        <= 1'b1;
                            mem_addr      <= '0;
                            mem_din       <= clear_color;
                            clear_done    <= (LAST_ADDR == '0);
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            mem_we <= 1'b0;
                        end
                    end else begin
                        if (clear_req) clear_pending <= 1'b1;
                        ox       <= nox;
                        oy       <= noy;
                        mem_we   <= p_in;
                        mem_addr <= paddr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, pixel colour width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, framebuffer address width.
REQ-003 SHALL have parameters H_RES, default 640, and V_RES, default 480, canvas size in pixels.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port clear_req  input  1  request to fill the whole canvas with clear_color.
REQ-007 SHALL have port clear_color  input  DATA_WIDTH  fill colour, sampled when the clear request is accepted.
REQ-008 SHALL have port stamp_valid  input  1  brush stamp request valid.
REQ-009 SHALL have port stamp_ready  output  1  scheduler can accept a stamp this cycle.
REQ-010 SHALL have port stamp_x  input  10  stamp top-left column.
REQ-011 SHALL have port stamp_y  input  10  stamp top-left row.
REQ-012 SHALL have port stamp_size  input  3  brush side minus one, so the side is 1..8 pixels.
REQ-013 SHALL have port stamp_color  input  DATA_WIDTH  brush colour.
REQ-014 SHALL have port busy  output  1  a clear or stamp write sequence is in progress.
REQ-015 SHALL have port clear_done  output  1  one-cycle pulse when a clear completes.
REQ-016 SHALL have port mem_we  output  1  framebuffer write enable.
REQ-017 SHALL have port mem_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-018 SHALL have port mem_din  output  DATA_WIDTH  framebuffer write data.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR and STAMP, with the port-side outputs (mem_*, busy, clear_done) registered.
REQ-020 SHALL compute every address as y*H_RES + x, zero-extended to ADDR_WIDTH.
REQ-021 SHALL drive stamp_ready = (state==IDLE) && !clear_req && !clear_pending; a stamp is accepted on stamp_valid && stamp_ready.
REQ-022 SHALL, on acceptance in IDLE, latch stamp_x, stamp_y, stamp_size and stamp_color, and enter STAMP.
REQ-023 SHALL give clear priority when clear_req and stamp_valid coincide in IDLE: the clear is accepted and the stamp is not.
REQ-024 SHALL, on a clear accepted at cycle T, write addresses 0..H_RES*V_RES-1 in ascending order, one per cycle, with mem_we=1 from T+1 to T+H_RES*V_RES and mem_din equal to the latched clear_color.
REQ-025 SHALL pulse clear_done for exactly one cycle, coincident with the last clear write, then return to IDLE.
REQ-026 SHALL visit the (size+1)x(size+1) positions of a stamp accepted at T in row-major order, one per cycle from T+1 to T+(size+1)^2.
REQ-027 SHALL, for each stamp position, drive mem_we=1 only if x<H_RES and y<V_RES, otherwise mem_we=0 with the cycle still consumed; clipping uses 11-bit sums and never wraps.
REQ-028 SHALL latch a clear_req arriving during STAMP into clear_pending, start that clear the cycle after the stamp ends, and clear clear_pending at that point.
REQ-029 SHALL ignore a clear_req arriving during CLEAR, with no restart and no pending set.
REQ-030 SHALL hold busy=1 exactly in the cycles where a write sequence position is output (T+1 .. end), and 0 otherwise.
REQ-031 SHALL drive mem_we=0 whenever busy=0; mem_addr and mem_din then hold their last values.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, force state IDLE, clear_pending=0, mem_we=0, mem_addr=0, mem_din=0, busy=0 and clear_done=0.
REQ-033 SHALL abort a CLEAR or STAMP immediately on reset, with no further writes, and keep stamp_ready=0 while rst=1.

Verification
REQ-034 SHALL cover a stamp at x=10, y=2, size=1, colour=5 -> 4 writes to addresses 1290, 1291, 1930, 1931 with din=5 in cycles T+1..T+4, then stamp_ready=1 at T+5.
REQ-035 SHALL cover a stamp at x=638, y=479, size=2 -> 9 cycles busy and writes only to 307198 and 307199; the other positions have we=0.
REQ-036 SHALL cover clear_req with clear_color=3 -> 307200 writes to addresses 0..307199, each with din=3, and clear_done high only at the write to 307199.
REQ-037 SHALL cover clear_req and stamp_valid in the same IDLE cycle -> the clear runs, stamp_ready stays 0, and the stamp is accepted the cycle after clear_done.
REQ-038 SHALL cover clear_req during a size=7 stamp -> all 64 stamp cycles complete, then the clear starts at addr 0 on the next cycle.
REQ-039 SHALL cover rst asserted mid-clear at addr 1000 -> no write on the following cycle, all outputs 0, and stamp_ready=1 once rst=0.
